// File: rtl/ntt_output_collector.sv
`default_nettype none
// ============================================================================
// ntt_output_collector - buffers one NTT result burst, then streams it out
// one coefficient per valid/ready beat.                Revision: 1.0
// ============================================================================
module ntt_output_collector #(
   parameter int LOG_CORE_COUNT = 4,
   parameter int LOG_N          = 12,
   parameter int COEFF_WIDTH    = 30
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     output_active,
   input  logic [2*COEFF_WIDTH-1:0] out [(1<<LOG_CORE_COUNT)-1:0][1:0],
   input  logic [8:0]               address_out,
   output logic                     free,
   output logic [COEFF_WIDTH-1:0]   m_data,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic                     m_last,
   output logic                     overflow,
   output logic                     short_burst
);

   localparam int CORES  = 1 << LOG_CORE_COUNT;
   localparam int ROW_W  = LOG_N - 2 - LOG_CORE_COUNT;
   localparam int ROWS   = 1 << ROW_W;
   localparam int BEATS  = 4 * CORES;
   localparam int K_W    = LOG_CORE_COUNT + 2;
   localparam int LINE_W = BEATS * COEFF_WIDTH;
   localparam int CNT_W  = 10;

   localparam logic [8:0]       C_ROWS_A   = 9'(ROWS);
   localparam logic [CNT_W-1:0] C_ROWS_C   = CNT_W'(ROWS);
   localparam logic [ROW_W-1:0] C_ROW_LAST = ROW_W'(ROWS - 1);
   localparam logic [K_W-1:0]   C_K_LAST   = K_W'(BEATS - 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_CAPTURE  = 3'd1,
      S_DRAIN_RD = 3'd2,
      S_DRAIN_LD = 3'd3,
      S_EMIT     = 3'd4
   } state_t;

   state_t                 state_q;
   logic [CNT_W-1:0]       row_cnt_q;
   logic [ROW_W-1:0]       row_q;
   logic [K_W-1:0]         k_q;
   logic                   overflow_q;
   logic                   short_q;
   logic [LINE_W-1:0]      rd_q;
   logic [COEFF_WIDTH-1:0] coef_q [BEATS];
   logic [LINE_W-1:0]      mem_q  [ROWS];

   logic [LINE_W-1:0]      w_row;
   logic                   w_in_range;
   logic                   w_capturing;
   logic                   w_we;

   // Word (core c, half h) lands at coefficient slots 4c+2h (lo) and 4c+2h+1 (hi).
   always_comb begin
      w_row = '0;
      for (int c = 0; c < CORES; c++) begin
         for (int h = 0; h < 2; h++) begin
            w_row[(c*2+h)*2*COEFF_WIDTH +: 2*COEFF_WIDTH] = out[c][h];
         end
      end
   end

   assign w_in_range  = (address_out < C_ROWS_A);
   assign w_capturing = (state_q == S_IDLE) || (state_q == S_CAPTURE);
   assign w_we        = output_active && w_in_range && w_capturing;

   always_ff @(posedge clk) begin
      if (w_we) begin
         mem_q[address_out[ROW_W-1:0]] <= w_row;
      end
      if (state_q == S_DRAIN_RD) begin
         rd_q <= mem_q[row_q];
      end
      if (state_q == S_DRAIN_LD) begin
         for (int b = 0; b < BEATS; b++) begin
            coef_q[b] <= rd_q[b*COEFF_WIDTH +: COEFF_WIDTH];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         row_cnt_q  <= '0;
         row_q      <= '0;
         k_q        <= '0;
         overflow_q <= 1'b0;
         short_q    <= 1'b0;
      end else begin
         // A burst arriving while draining is dropped, including one that
         // coincides with the final accept.
         if (output_active && !w_capturing) begin
            overflow_q <= 1'b1;
         end
         case (state_q)
            S_IDLE: begin
               if (output_active) begin
                  row_cnt_q <= w_in_range ? CNT_W'(1) : '0;
                  state_q   <= S_CAPTURE;
               end
            end
            S_CAPTURE: begin
               if (output_active) begin
                  if (w_in_range && (row_cnt_q != '1)) begin
                     row_cnt_q <= row_cnt_q + CNT_W'(1);
                  end
               end else if (row_cnt_q == C_ROWS_C) begin
                  row_q   <= '0;
                  state_q <= S_DRAIN_RD;
               end else begin
                  short_q <= 1'b1;
                  state_q <= S_IDLE;
               end
            end
            S_DRAIN_RD: begin
               state_q <= S_DRAIN_LD;
            end
            S_DRAIN_LD: begin
               k_q     <= '0;
               state_q <= S_EMIT;
            end
            S_EMIT: begin
               if (m_ready) begin
                  if (k_q == C_K_LAST) begin
                     k_q <= '0;
                     if (row_q == C_ROW_LAST) begin
                        state_q <= S_IDLE;
                     end else begin
                        row_q   <= row_q + ROW_W'(1);
                        state_q <= S_DRAIN_RD;
                     end
                  end else begin
                     k_q <= k_q + K_W'(1);
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign free        = (state_q == S_IDLE);
   assign m_valid     = (state_q == S_EMIT);
   assign m_data      = m_valid ? coef_q[k_q] : '0;
   assign m_last      = m_valid && (row_q == C_ROW_LAST) && (k_q == C_K_LAST);
   assign overflow    = overflow_q;
   assign short_burst = short_q;

endmodule
`default_nettype wire

// File: doc/ntt_output_collector.md
Name: ntt_output_collector

Overview:
- Receiving end of the NTT processor result interface.
- Captures one complete result burst, i.e. one row per cycle of 2×CORES packed words while output_active is high, into an internal row buffer.
- Then drains the result as a serial stream of coefficients over a valid/ready interface to the host-side DMA.
- Decouples the non-stallable processor output from a back-pressured consumer; free tells the controller when the next NTT may be started.

Parameters:
- LOG_CORE_COUNT, 4, log2 of core count; CORES = 1 << LOG_CORE_COUNT.
- LOG_N, 12, log2 of transform length; ROWS = 1 << (LOG_N - 2 - LOG_CORE_COUNT) = 64.
- COEFF_WIDTH, 30, bits per coefficient; packed word = 2×COEFF_WIDTH = 60.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- output_active  in  1  high in every cycle where out and address_out carry a valid row.
- out  in  [2*COEFF_WIDTH-1:0] unpacked [CORES-1:0][1:0]  result words per core and half.
- address_out  in  9  row index of the current burst cycle.
- free  out  1  buffer idle; a new NTT may be started.
- m_data  out  COEFF_WIDTH  coefficient stream data.
- m_valid  out  1  m_data valid.
- m_ready  in  1  consumer accepts the beat when m_valid && m_ready.
- m_last  out  1  high with the final (4096th) coefficient beat.
- overflow  out  1  sticky: a burst arrived while the buffer was busy.
- short_burst  out  1  sticky: a burst ended with the wrong row count.

Behaviour:
- Reset (async, rst=1): state IDLE, free=1, m_valid=0, m_last=0, m_data=0, overflow=0, short_burst=0, all counters 0. Buffer contents undefined. Reset mid-capture or mid-drain aborts immediately; no beats are emitted after reset release until a new burst.
- Storage: ROWS × (CORES·2·2·COEFF_WIDTH) RAM, 1-cycle synchronous read.
- IDLE: free=1. output_active=1 → write row to RAM[address_out], row_count=1, go CAPTURE. The first row is written in the same cycle.
- CAPTURE: free=0.
  - Each cycle with output_active=1 and address_out<ROWS: write row, row_count+1.
  - address_out≥ROWS: row not written, not counted.
  - Duplicate address: last write wins, still counted.
  - On output_active=0: row_count==ROWS → DRAIN_RD with row=0.
  - On output_active=0 with any other row_count: set short_burst, go IDLE; nothing emitted.
- DRAIN_RD: issue RAM read of row; next state DRAIN_LD.
- DRAIN_LD: latch RAM output into row register, k=0; next state EMIT.
- EMIT: m_valid=1.
  - Beat k (0..4·CORES−1) selects word w=k>>1, core=w>>1, half=w&1.
  - m_data = out-word[COEFF_WIDTH-1:0] when k even, [2·COEFF_WIDTH-1:COEFF_WIDTH] when k odd.
  - Global coefficient index = row·4·CORES + k.
  - m_last=1 only when row=ROWS−1 and k=4·CORES−1.
- Handshake:
  - While m_valid=1 and m_ready=0, m_data and m_last hold stable.
  - On accept: k+1.
  - On accept of k=4·CORES−1: row=ROWS−1 → IDLE (m_valid=0 next cycle); otherwise row+1 → DRAIN_RD.
  - Hence m_valid is low for exactly 2 cycles between rows and 2 cycles after CAPTURE ends.
  - m_valid never deasserts without an accept.
- Throughput with m_ready=1: 64 beats per 66 cycles. Full drain = ROWS·(4·CORES+2) = 4224 cycles from leaving CAPTURE to the last accept.
- Overflow: output_active=1 in any state other than IDLE/CAPTURE sets overflow. The burst is ignored and the current drain continues unaffected. output_active rising in the same cycle as the final accept also sets overflow; IDLE is only entered the cycle after.
- free deasserts the cycle after the first captured row and reasserts the cycle after the final accept.
- overflow and short_burst clear only on rst.

Test Plan:
- Full burst, counting pattern: word(core c, half h, row r) = {hi=r·64+c·4+h·2+1, lo=r·64+c·4+h·2}, 64 rows, m_ready=1 → 4096 beats with m_data=0,1,…,4095; m_last only on 4095; drain 4224 cycles; free=1 after; flags 0.
- Same burst, m_ready random 50% → identical data order; m_data/m_last stable during every stall; no beat lost or duplicated.
- Burst of 63 rows (output_active drops early) → short_burst=1, zero beats, free=1 next cycle; a following correct 64-row burst drains normally.
- Second burst starts during drain (at beat 1000) → overflow=1, first result emitted intact (0..4095), second burst discarded.
- rst pulsed at beat 2000 of the drain → m_valid=0 immediately, flags 0, free=1; a new full burst then drains 0..4095 correctly.
- Rows written in reverse address order (63→0) → output still in row order 0..63, i.e. m_data=0..4095.
